// File: rtl/arrow_track_pool.sv
`timescale 1ns/1ps
// arrow_track_pool
//   Pool of ARROW_COUNT arrow slots spread over LANES lanes. Each slot scrolls
//   an arrow up-screen once per frame until a button press hits it or it runs
//   off the top (miss). Results are serialised one per cycle onto the judge
//   outputs.
//
//   Slot FSM:
//     state   | meaning
//     --------+-----------------------------------------------------------
//     S_IDLE  | free; y parked at ARROWY_BEGIN, eligible for allocation
//     S_LOAD  | allocated this cycle; drives next_o to advance chart RAM
//     S_MOVE  | scrolling; y drops ARROW_SPEED per frame, hittable low down
//     S_JUDGE | graded (hit/miss), waiting for its turn on the judge port
//
// Ports:
//   clk_i, reset_n_i      clock, async active-low reset
//   frame_i               one-cycle pulse per video frame
//   launch_i              launch request, lane on launch_lane_i
//   btn_i                 per-lane button levels (already synchronised)
//   arrow_y_o             slot k y at [k*CORDW +: CORDW]
//   arrow_lane_o          slot k lane at [k*LANE_W +: LANE_W]
//   active_o              slot k is scrolling
//   next_o                any slot loading
//   overflow_o            pulse: launch dropped, no free slot
//   judge_valid_o/hit/lane/y  one judge report per pulse (y = 0 on miss)

module arrow_track_pool #(
  parameter int CORDW        = 10,
  parameter int ARROWY_BEGIN = 480,
  parameter int ARROW_SPEED  = 5,
  parameter int HIT_WINDOW   = 125,
  parameter int ARROW_COUNT  = 4,
  parameter int LANES        = 4,
  parameter int LANE_W       = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          frame_i,
  input  logic                          launch_i,
  input  logic [LANE_W-1:0]             launch_lane_i,
  input  logic [LANES-1:0]              btn_i,
  output logic [CORDW*ARROW_COUNT-1:0]  arrow_y_o,
  output logic [LANE_W*ARROW_COUNT-1:0] arrow_lane_o,
  output logic [ARROW_COUNT-1:0]        active_o,
  output logic                          next_o,
  output logic                          overflow_o,
  output logic                          judge_valid_o,
  output logic                          judge_hit_o,
  output logic [LANE_W-1:0]             judge_lane_o,
  output logic [CORDW-1:0]              judge_y_o
);

  localparam int IDX_W = (ARROW_COUNT > 1) ? $clog2(ARROW_COUNT) : 1;

  localparam logic [CORDW-1:0] Y_BEGIN = CORDW'(ARROWY_BEGIN);
  localparam logic [CORDW-1:0] Y_STEP  = CORDW'(ARROW_SPEED);
  localparam logic [CORDW-1:0] Y_WIN   = CORDW'(HIT_WINDOW);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_MOVE  = 2'd2,
    S_JUDGE = 2'd3
  } slot_state_e;

  slot_state_e             state_q [ARROW_COUNT];
  slot_state_e             state_d [ARROW_COUNT];
  logic [CORDW-1:0]        y_q     [ARROW_COUNT];
  logic [CORDW-1:0]        y_d     [ARROW_COUNT];
  logic [LANE_W-1:0]       lane_q  [ARROW_COUNT];
  logic [LANE_W-1:0]       lane_d  [ARROW_COUNT];
  logic [ARROW_COUNT-1:0]  hit_q;
  logic [ARROW_COUNT-1:0]  hit_d;

  logic [LANES-1:0]        btn_q;
  logic [LANES-1:0]        press;

  logic [ARROW_COUNT-1:0]  alloc_vec;
  logic                    alloc_found;

  logic [ARROW_COUNT-1:0]  hit_vec;
  logic                    best_found;
  logic [CORDW-1:0]        best_y;
  logic [IDX_W-1:0]        best_idx;

  logic [ARROW_COUNT-1:0]  rep_vec;
  logic                    rep_any;
  logic                    rep_hit;
  logic [LANE_W-1:0]       rep_lane;
  logic [CORDW-1:0]        rep_y;

  // Rising edge of each button; a held button counts once.
  assign press = btn_i & ~btn_q;

  // Lowest-index free slot takes the launch. A slot draining JUDGE this cycle
  // is not S_IDLE yet, so it cannot be picked.
  always_comb begin
    alloc_vec   = '0;
    alloc_found = 1'b0;
    for (int k = 0; k < ARROW_COUNT; k++) begin
      if (!alloc_found && (state_q[k] == S_IDLE)) begin
        alloc_vec[k] = launch_i;
        alloc_found  = 1'b1;
      end
    end
  end

  // Per lane: the eligible arrow nearest the top (lowest y) takes the press;
  // strict '<' keeps the lowest index on a tie.
  always_comb begin
    hit_vec    = '0;
    best_found = 1'b0;
    best_y     = '0;
    best_idx   = '0;
    for (int l = 0; l < LANES; l++) begin
      best_found = 1'b0;
      best_y     = '0;
      best_idx   = '0;
      for (int k = 0; k < ARROW_COUNT; k++) begin
        if (press[l] && (state_q[k] == S_MOVE) &&
            (lane_q[k] == LANE_W'(l)) && (y_q[k] <= Y_WIN) &&
            (!best_found || (y_q[k] < best_y))) begin
          best_found = 1'b1;
          best_y     = y_q[k];
          best_idx   = IDX_W'(k);
        end
      end
      if (best_found) begin
        hit_vec[best_idx] = 1'b1;
      end
    end
  end

  // One judge report per cycle, lowest index first; the rest wait in S_JUDGE.
  always_comb begin
    rep_vec  = '0;
    rep_any  = 1'b0;
    rep_hit  = 1'b0;
    rep_lane = '0;
    rep_y    = '0;
    for (int k = 0; k < ARROW_COUNT; k++) begin
      if (!rep_any && (state_q[k] == S_JUDGE)) begin
        rep_any    = 1'b1;
        rep_vec[k] = 1'b1;
        rep_hit    = hit_q[k];
        rep_lane   = lane_q[k];
        rep_y      = hit_q[k] ? y_q[k] : '0;
      end
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int k = 0; k < ARROW_COUNT; k++) begin
        state_q[k] <= S_IDLE;
        y_q[k]     <= Y_BEGIN;
        lane_q[k]  <= '0;
      end
      hit_q <= '0;
    end else begin
      for (int k = 0; k < ARROW_COUNT; k++) begin
        state_q[k] <= state_d[k];
        y_q[k]     <= y_d[k];
        lane_q[k]  <= lane_d[k];
      end
      hit_q <= hit_d;
    end
  end

  // Next-state logic. A hit outranks a same-cycle frame tick, so the
  // captured y is the pre-tick value. A miss is declared instead of letting
  // y wrap below zero.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    lane_d  = lane_q;
    hit_d   = hit_q;
    for (int k = 0; k < ARROW_COUNT; k++) begin
      case (state_q[k])
        S_IDLE: begin
          if (alloc_vec[k]) begin
            state_d[k] = S_LOAD;
            y_d[k]     = Y_BEGIN;
            lane_d[k]  = launch_lane_i;
          end
        end
        S_LOAD: begin
          state_d[k] = S_MOVE;
        end
        S_MOVE: begin
          if (hit_vec[k]) begin
            state_d[k] = S_JUDGE;
            hit_d[k]   = 1'b1;
          end else if (frame_i) begin
            if (y_q[k] >= Y_STEP) begin
              y_d[k] = y_q[k] - Y_STEP;
            end else begin
              state_d[k] = S_JUDGE;
              hit_d[k]   = 1'b0;
            end
          end
        end
        S_JUDGE: begin
          if (rep_vec[k]) begin
            state_d[k] = S_IDLE;
            y_d[k]     = Y_BEGIN;
          end
        end
        default: begin
          state_d[k] = S_IDLE;
        end
      endcase
    end
  end

  // Output logic
  always_comb begin
    arrow_y_o    = '0;
    arrow_lane_o = '0;
    active_o     = '0;
    next_o       = 1'b0;
    for (int k = 0; k < ARROW_COUNT; k++) begin
      arrow_y_o[k*CORDW +: CORDW]     = y_q[k];
      arrow_lane_o[k*LANE_W +: LANE_W] = lane_q[k];
      active_o[k]                      = (state_q[k] == S_MOVE);
      next_o                           = next_o | (state_q[k] == S_LOAD);
    end
  end

  // Registered side-band: button history, overflow pulse, judge port.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      btn_q         <= '0;
      overflow_o    <= 1'b0;
      judge_valid_o <= 1'b0;
      judge_hit_o   <= 1'b0;
      judge_lane_o  <= '0;
      judge_y_o     <= '0;
    end else begin
      btn_q         <= btn_i;
      overflow_o    <= launch_i & ~alloc_found;
      judge_valid_o <= rep_any;
      judge_hit_o   <= rep_hit;
      judge_lane_o  <= rep_lane;
      judge_y_o     <= rep_y;
    end
  end

endmodule

// File: tb/tb_arrow_track_pool.sv
`timescale 1ns/1ps
// Bench for arrow_track_pool: a rule-level model of the slot pool checked
// against the DUT every cycle, plus directed scenarios with literal values.

module tb_arrow_track_pool;

  localparam int N     = 4;
  localparam int NL    = 4;
  localparam int CW    = 10;
  localparam int LW    = 2;
  localparam int BEGIN = 480;
  localparam int SPEED = 5;
  localparam int WIN   = 125;

  logic              clk_i;
  logic              reset_n_i;
  logic              frame_i;
  logic              launch_i;
  logic [LW-1:0]     launch_lane_i;
  logic [NL-1:0]     btn_i;
  logic [CW*N-1:0]   arrow_y_o;
  logic [LW*N-1:0]   arrow_lane_o;
  logic [N-1:0]      active_o;
  logic              next_o;
  logic              overflow_o;
  logic              judge_valid_o;
  logic              judge_hit_o;
  logic [LW-1:0]     judge_lane_o;
  logic [CW-1:0]     judge_y_o;

  arrow_track_pool dut (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .frame_i       (frame_i),
    .launch_i      (launch_i),
    .launch_lane_i (launch_lane_i),
    .btn_i         (btn_i),
    .arrow_y_o     (arrow_y_o),
    .arrow_lane_o  (arrow_lane_o),
    .active_o      (active_o),
    .next_o        (next_o),
    .overflow_o    (overflow_o),
    .judge_valid_o (judge_valid_o),
    .judge_hit_o   (judge_hit_o),
    .judge_lane_o  (judge_lane_o),
    .judge_y_o     (judge_y_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;
  int j_count  = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // kind: 0 free, 1 loading, 2 scrolling, 3 graded-awaiting-report
  int              m_kind [N];
  int              m_y    [N];
  int              m_lane [N];
  bit              m_hit  [N];
  logic [NL-1:0]   m_btn_prev;
  bit              e_ovf, e_jv, e_jh;
  int              e_jl, e_jy;

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_kind[k] = 0; m_y[k] = BEGIN; m_lane[k] = 0; m_hit[k] = 0;
    end
    m_btn_prev = '0;
    e_ovf = 0; e_jv = 0; e_jh = 0; e_jl = 0; e_jy = 0;
  endtask

  task automatic model_step();
    int pk [N];
    int rep, alloc, best;
    bit win [N];
    logic [NL-1:0] pr;
    pk   = m_kind;
    pr   = btn_i & ~m_btn_prev;
    m_btn_prev = btn_i;
    rep = -1;
    for (int k = 0; k < N; k++) if (pk[k] == 3 && rep < 0) rep = k;
    alloc = -1;
    if (launch_i) for (int k = 0; k < N; k++) if (pk[k] == 0 && alloc < 0) alloc = k;
    e_ovf = launch_i && (alloc < 0);
    for (int k = 0; k < N; k++) win[k] = 0;
    for (int l = 0; l < NL; l++) begin
      best = -1;
      if (pr[l]) begin
        for (int k = 0; k < N; k++)
          if (pk[k] == 2 && m_lane[k] == l && m_y[k] <= WIN)
            if (best < 0 || m_y[k] < m_y[best]) best = k;
      end
      if (best >= 0) win[best] = 1;
    end
    if (rep >= 0) begin
      e_jv = 1; e_jh = m_hit[rep]; e_jl = m_lane[rep];
      e_jy = m_hit[rep] ? m_y[rep] : 0;
    end else begin
      e_jv = 0; e_jh = 0; e_jl = 0; e_jy = 0;
    end
    for (int k = 0; k < N; k++) begin
      if (pk[k] == 0 && k == alloc) begin
        m_kind[k] = 1; m_y[k] = BEGIN; m_lane[k] = int'(launch_lane_i);
      end else if (pk[k] == 1) begin
        m_kind[k] = 2;
      end else if (pk[k] == 2) begin
        if (win[k]) begin
          m_kind[k] = 3; m_hit[k] = 1;
        end else if (frame_i) begin
          if (m_y[k] >= SPEED) m_y[k] = m_y[k] - SPEED;
          else begin m_kind[k] = 3; m_hit[k] = 0; end
        end
      end else if (pk[k] == 3 && k == rep) begin
        m_kind[k] = 0; m_y[k] = BEGIN;
      end
    end
  endtask

  always @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) model_reset();
    else            model_step();
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_i) begin
    if (chk_en) begin
      bit en;
      en = 0;
      for (int k = 0; k < N; k++) begin
        check($sformatf("mdl_y%0d", k), arrow_y_o[k*CW +: CW], m_y[k]);
        check($sformatf("mdl_lane%0d", k), arrow_lane_o[k*LW +: LW], m_lane[k]);
        check($sformatf("mdl_active%0d", k), active_o[k], m_kind[k] == 2);
        if (m_kind[k] == 1) en = 1;
      end
      check("mdl_next", next_o, en);
      check("mdl_overflow", overflow_o, e_ovf);
      check("mdl_jvalid", judge_valid_o, e_jv);
      if (e_jv) begin
        check("mdl_jhit", judge_hit_o, e_jh);
        check("mdl_jlane", judge_lane_o, e_jl);
        check("mdl_jy", judge_y_o, e_jy);
      end
    end
    if (judge_valid_o === 1'b1) j_count++;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic launch(input int lane);
    launch_i = 1'b1;
    launch_lane_i = LW'(lane);
    step();
    launch_i = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_i = 1'b1;
      step();
      frame_i = 1'b0;
    end
  endtask

  task automatic do_reset();
    launch_i = 0; frame_i = 0; btn_i = '0;
    reset_n_i = 1'b0;
    step();
    step();
    reset_n_i = 1'b1;
    step();
  endtask

  function automatic int slot_y(input int k);
    return int'(arrow_y_o[k*CW +: CW]);
  endfunction

  function automatic int slot_lane(input int k);
    return int'(arrow_lane_o[k*LW +: LW]);
  endfunction

  logic [CW*N-1:0] y_rst;
  int j0;

  initial begin
    y_rst = {N{10'd480}};
    reset_n_i = 0; frame_i = 0; launch_i = 0; launch_lane_i = '0; btn_i = '0;
    repeat (3) step();
    reset_n_i = 1;
    step();
    chk_en = 1;

    // reset state
    check("rst_y", arrow_y_o, y_rst);
    check("rst_lane", arrow_lane_o, 0);
    check("rst_active", active_o, 0);
    check("rst_next", next_o, 0);
    check("rst_jvalid", judge_valid_o, 0);
    check("rst_overflow", overflow_o, 0);

    // single launch on lane 2
    launch(2);
    check("s1_next_load", next_o, 1);
    check("s1_active_load", active_o, 0);
    step();
    check("s1_next_move", next_o, 0);
    check("s1_active_move", active_o, 4'b0001);
    check("s1_y0", slot_y(0), 480);
    check("s1_lane0", slot_lane(0), 2);
    frames(1);
    check("s1_y1", slot_y(0), 475);
    frames(1);
    check("s1_y2", slot_y(0), 470);

    // hit at y = 120, then ignored press at y = 130
    do_reset();
    launch(1); step();
    frames(72);
    check("s2_y120", slot_y(0), 120);
    btn_i[1] = 1; step(); step();
    check("s2_jvalid", judge_valid_o, 1);
    check("s2_jhit", judge_hit_o, 1);
    check("s2_jlane", judge_lane_o, 1);
    check("s2_jy", judge_y_o, 120);
    check("s2_y_back", slot_y(0), 480);
    check("s2_idle", active_o, 0);
    btn_i[1] = 0;
    launch(1); step();
    frames(70);
    check("s2_y130", slot_y(0), 130);
    j0 = j_count;
    btn_i[1] = 1; step(); step();
    check("s2_nojudge", j_count - j0, 0);
    check("s2_still_active", active_o, 4'b0001);
    btn_i[1] = 0; step();

    // miss
    do_reset();
    launch(0); step();
    frames(96);
    check("s3_y0", slot_y(0), 0);
    check("s3_active", active_o, 4'b0001);
    frames(1);
    check("s3_nowrap", slot_y(0), 0);
    check("s3_judging", active_o, 0);
    step();
    check("s3_jvalid", judge_valid_o, 1);
    check("s3_jhit", judge_hit_o, 0);
    check("s3_jy", judge_y_o, 0);
    check("s3_y_back", slot_y(0), 480);

    // overflow and reallocation
    do_reset();
    launch(0); launch(1); launch(2); launch(3);
    launch(3);
    check("s4_overflow", overflow_o, 1);
    check("s4_lanes", arrow_lane_o, 8'hE4);
    step();
    check("s4_overflow_off", overflow_o, 0);
    check("s4_all_active", active_o, 4'hF);
    frames(72);
    btn_i[1] = 1; step(); step();
    check("s4_jlane", judge_lane_o, 1);
    check("s4_jy", judge_y_o, 120);
    check("s4_active", active_o, 4'b1101);
    btn_i[1] = 0;
    launch(3);
    check("s4_next", next_o, 1);
    check("s4_realloc_lane", slot_lane(1), 3);
    check("s4_realloc_y", slot_y(1), 480);

    // lowest y wins over lowest index
    do_reset();
    launch(3); step();
    frames(72);
    launch(0); step();
    frames(10);
    btn_i[3] = 1; step(); btn_i[3] = 0; step();
    check("s5_d_lane", judge_lane_o, 3);
    check("s5_d_y", judge_y_o, 70);
    launch(0); step();
    frames(76);
    check("s5_y_slot1", slot_y(1), 50);
    check("s5_y_slot0", slot_y(0), 100);
    btn_i[0] = 1; step(); step();
    check("s5_jy", judge_y_o, 50);
    check("s5_jlane", judge_lane_o, 0);
    check("s5_active", active_o, 4'b0001);
    btn_i[0] = 0; step();

    // two lanes in one cycle
    do_reset();
    launch(1); launch(0); step();
    frames(72);
    btn_i = 4'b0011; step(); step();
    check("s6_first_valid", judge_valid_o, 1);
    check("s6_first_lane", judge_lane_o, 1);
    step();
    check("s6_second_valid", judge_valid_o, 1);
    check("s6_second_lane", judge_lane_o, 0);
    step();
    check("s6_done", judge_valid_o, 0);
    btn_i = '0;

    // held button hits once
    do_reset();
    launch(2); launch(2); step();
    frames(72);
    j0 = j_count;
    btn_i[2] = 1;
    repeat (6) step();
    check("s7_one_hit", j_count - j0, 1);
    check("s7_active", active_o, 4'b0010);
    btn_i = '0;

    // hit coincident with frame tick
    do_reset();
    launch(0); step();
    frames(72);
    btn_i[0] = 1; frame_i = 1; step(); frame_i = 0; step();
    check("s8_jvalid", judge_valid_o, 1);
    check("s8_pretick_y", judge_y_o, 120);
    btn_i = '0;

    // async reset with a judge pending
    do_reset();
    launch(0); step();
    frames(72);
    btn_i[0] = 1; step();
    #1 reset_n_i = 0;
    #1;
    check("s9_active", active_o, 0);
    check("s9_y", arrow_y_o, y_rst);
    check("s9_next", next_o, 0);
    check("s9_jvalid", judge_valid_o, 0);
    j0 = j_count;
    btn_i = '0;
    step(); step();
    reset_n_i = 1;
    repeat (4) step();
    check("s9_no_judge", j_count - j0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
